// File: rtl/ppm_frame_sequencer.sv
// PPM receiver frame sequencer: oversamples ppm_in, timestamps rising edges in
// prescaled ticks, collects channel widths into a shadow bank and commits whole
// frames to an output bank read through rd_ch/rd_data with a valid/ack handshake.
// Optional signal-loss failsafe is compiled in with `define PPM_FAILSAFE_EN.
module ppm_frame_sequencer #(
  parameter int CLK_DIV   = 15,     // clk cycles per measurement tick (>= 1)
  parameter int MAX_CH    = 8,      // maximum channels per frame (1..15)
  parameter int MIN_CH    = 4,      // minimum channels for a frame to commit
  parameter int MIN_PULSE = 500,    // shortest legal channel interval, ticks
  parameter int SYNC_MIN  = 3000,   // interval >= this is a sync gap, ticks
  parameter int TIMEOUT   = 20000   // ticks without a rise before failsafe
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ppm_in,
  input  logic [3:0]  rd_ch,
  output logic [15:0] rd_data,
  output logic [3:0]  ch_count,
  output logic        frame_valid,
  input  logic        frame_ack,
  output logic        sync_pulse,
  output logic        overrun,
  output logic        failsafe
);

  // Parameters narrowed to the widths of the signals they are compared with.
  localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);
  localparam logic [3:0]  MAX_CH_L    = 4'(MAX_CH);
  localparam logic [3:0]  MIN_CH_L    = 4'(MIN_CH);
  localparam logic [15:0] MIN_PULSE_L = 16'(MIN_PULSE);
  localparam logic [15:0] SYNC_MIN_L  = 16'(SYNC_MIN);
  localparam logic [15:0] TIMEOUT_L   = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  ch_idx;

  logic        sync1;
  logic        sync2;
  logic        sync_d;
  logic        rise;

  logic [15:0] pre_cnt;
  logic        tick;
  logic [15:0] width;
  logic        timeout;

  // Banks are sized for the largest legal MAX_CH; entries at or above MAX_CH
  // are never written and are masked on the read side.
  logic [15:0] shadow [16];
  logic [15:0] bank   [16];

  // Two-flop synchroniser plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= ppm_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync_d;
  assign tick = (pre_cnt == DIV_LAST);

  // Tick prescaler; re-phased on every rise so W counts whole ticks since it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= 16'd0;
    end else if (rise || tick) begin
      pre_cnt <= 16'd0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  // Interval counter: holds W during the rise cycle, then restarts; saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width <= 16'd0;
    end else if (rise) begin
      width <= 16'd0;
    end else if (tick && (width != 16'hFFFF)) begin
      width <= width + 16'd1;
    end
  end

`ifdef PPM_FAILSAFE_EN
  // Fires once, on the tick that carries the counter up to TIMEOUT.
  assign timeout = tick & ~rise & (width == (TIMEOUT_L - 16'd1));
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT_L;
`endif

  // Frame state machine with registered bank, handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      ch_idx      <= 4'd0;
      shadow      <= '{default: 16'd0};
      bank        <= '{default: 16'd0};
      ch_count    <= 4'd0;
      frame_valid <= 1'b0;
      sync_pulse  <= 1'b0;
      overrun     <= 1'b0;
      failsafe    <= 1'b0;
    end else begin
      sync_pulse <= 1'b0;
      // Consumer ack drops valid; a commit in the same cycle overrides below.
      if (frame_ack) begin
        frame_valid <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (rise && (width >= SYNC_MIN_L)) begin
            state  <= CAPTURE;
            ch_idx <= 4'd0;
          end
        end

        CAPTURE: begin
          if (rise) begin
            if (width >= SYNC_MIN_L) begin
              // Sync closes the frame; too few channels restarts silently.
              if (ch_idx >= MIN_CH_L) begin
                state <= COMMIT;
              end else begin
                ch_idx <= 4'd0;
              end
            end else if ((width < MIN_PULSE_L) || (ch_idx == MAX_CH_L)) begin
              // Runt pulse or too many channels: frame is corrupt.
              state  <= HUNT;
              ch_idx <= 4'd0;
            end else begin
              shadow[ch_idx] <= width;
              ch_idx         <= ch_idx + 4'd1;
            end
          end
        end

        COMMIT: begin
          bank        <= shadow;
          ch_count    <= ch_idx;
          sync_pulse  <= 1'b1;
          frame_valid <= 1'b1;
          failsafe    <= 1'b0;
          if (frame_valid && !frame_ack) begin
            overrun <= 1'b1;
          end
          ch_idx <= 4'd0;
          state  <= CAPTURE;
        end

        default: begin
          state  <= HUNT;
          ch_idx <= 4'd0;
        end
      endcase

      // Signal loss drops the pending frame but keeps the bank readable.
      if (timeout) begin
        failsafe    <= 1'b1;
        frame_valid <= 1'b0;
        state       <= HUNT;
        ch_idx      <= 4'd0;
      end
    end
  end

  // Output bank read port; out-of-range or uncommitted channels read as 0.
  always_comb begin
    rd_data = 16'd0;
    if ((rd_ch < MAX_CH_L) && (rd_ch < ch_count)) begin
      rd_data = bank[rd_ch];
    end
  end

endmodule

// File: tb/tb_ppm_frame_sequencer.sv
// Directed bench for ppm_frame_sequencer. Tick thresholds are scaled down
// (CLK_DIV=2, SYNC_MIN=300, MIN_PULSE=50, TIMEOUT=1000) to keep frames short;
// rises spaced 2*W+1 clk apart measure exactly W ticks.
module tb_ppm_frame_sequencer;

  logic        clk;
  logic        reset;
  logic        ppm_in;
  logic [3:0]  rd_ch;
  logic [15:0] rd_data;
  logic [3:0]  ch_count;
  logic        frame_valid;
  logic        frame_ack;
  logic        sync_pulse;
  logic        overrun;
  logic        failsafe;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_rise   = 0;
  int commits     = 0;
  int base_commits;

  ppm_frame_sequencer #(
    .CLK_DIV  (2),
    .MAX_CH   (8),
    .MIN_CH   (4),
    .MIN_PULSE(50),
    .SYNC_MIN (300),
    .TIMEOUT  (1000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ppm_in     (ppm_in),
    .rd_ch      (rd_ch),
    .rd_data    (rd_data),
    .ch_count   (ch_count),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .sync_pulse (sync_pulse),
    .overrun    (overrun),
    .failsafe   (failsafe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Commit strobes counted on the falling edge, away from the update edge.
  always @(negedge clk) if (sync_pulse === 1'b1) commits <= commits + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Rise on ppm_in 2*w+1 clk after the previous one; returns 3 clk after the
  // rise is driven, i.e. in the COMMIT cycle if this rise closed a frame.
  task automatic rise_after(input int w);
    ppm_in = 1'b0;
    wait_until(last_rise + 2 * w + 1);
    ppm_in    = 1'b1;
    last_rise = cyc;
    repeat (3) step();
  endtask

  task automatic send_n(input int w, input int n);
    for (int k = 0; k < n; k++) rise_after(w);
  endtask

  task automatic rd_check(input string tag, input int ch, input int exp);
    rd_ch = 4'(ch);
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    ppm_in    = 1'b0;
    rd_ch     = 4'd0;
    frame_ack = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_fv", 32'(frame_valid), 0);
    check("rst_sp", 32'(sync_pulse), 0);
    check("rst_cc", 32'(ch_count), 0);
    check("rst_ov", 32'(overrun), 0);
    check("rst_fs", 32'(failsafe), 0);
    check("rst_rd", 32'(rd_data), 0);
    reset     = 1'b0;
    last_rise = cyc;

    // Nominal 8-channel frame with distinct widths 150..220
    rise_after(400);
    rise_after(400);
    for (int i = 0; i < 8; i++) rise_after(150 + 10 * i);
    rise_after(400);
    check("nom_fv_commit_cycle", 32'(frame_valid), 0);
    check("nom_sp_commit_cycle", 32'(sync_pulse), 0);
    step();
    check("nom_fv", 32'(frame_valid), 1);
    check("nom_sp", 32'(sync_pulse), 1);
    check("nom_cc", 32'(ch_count), 8);
    step();
    check("nom_sp_one_clk", 32'(sync_pulse), 0);
    for (int i = 0; i < 8; i++) rd_check($sformatf("nom_ch%0d", i), i, 150 + 10 * i);
    rd_check("nom_ch8", 8, 0);
    rd_check("nom_ch9", 9, 0);
    check("nom_ov", 32'(overrun), 0);
    check("nom_commits", 32'(commits), 1);

    // Ack on the next cycle clears valid one clk later
    frame_ack = 1'b1;
    check("ack_fv_before", 32'(frame_valid), 1);
    step();
    frame_ack = 1'b0;
    check("ack_fv_after", 32'(frame_valid), 0);

    // Runt pulse mid-frame -> HUNT, bank untouched
    send_n(150, 2);
    rise_after(30);
    repeat (3) step();
    check("runt_fv", 32'(frame_valid), 0);
    check("runt_commits", 32'(commits), 1);
    rd_check("runt_bank_ch0", 0, 150);
    // Recovery: sync, 5 channels, sync
    rise_after(400);
    send_n(170, 5);
    rise_after(400);
    step();
    check("rec_fv", 32'(frame_valid), 1);
    check("rec_cc", 32'(ch_count), 5);
    check("rec_ov", 32'(overrun), 0);
    rd_check("rec_ch0", 0, 170);
    rd_check("rec_ch4", 4, 170);
    rd_check("rec_ch5_above_count", 5, 0);

    // Short frame (3 channels) is dropped; 4 channels commits with ack in COMMIT
    send_n(190, 3);
    rise_after(400);
    repeat (3) step();
    check("short_commits", 32'(commits), 2);
    check("short_cc", 32'(ch_count), 5);
    send_n(180, 4);
    rise_after(400);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check("ackc_fv", 32'(frame_valid), 1);
    check("ackc_sp", 32'(sync_pulse), 1);
    check("ackc_ov", 32'(overrun), 0);
    check("ackc_cc", 32'(ch_count), 4);
    step();
    check("ackc_fv_hold", 32'(frame_valid), 1);
    rd_check("ackc_ch3", 3, 180);
    rd_check("ackc_ch4", 4, 0);

    // Channel overflow: 9 channels with MAX_CH=8 -> discarded
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check("ovf_pre_fv", 32'(frame_valid), 0);
    send_n(160, 9);
    rise_after(400);
    repeat (3) step();
    check("ovf_fv", 32'(frame_valid), 0);
    check("ovf_commits", 32'(commits), 3);
    check("ovf_cc", 32'(ch_count), 4);
    rd_check("ovf_ch0", 0, 180);

    // Two frames without ack -> overrun, bank shows second frame
    send_n(200, 6);
    rise_after(400);
    step();
    check("dbl1_fv", 32'(frame_valid), 1);
    check("dbl1_ov", 32'(overrun), 0);
    send_n(210, 7);
    rise_after(400);
    step();
    check("dbl2_ov", 32'(overrun), 1);
    check("dbl2_cc", 32'(ch_count), 7);
    rd_check("dbl2_ch6", 6, 210);
    rd_check("dbl2_ch0", 0, 210);

    // Line held low past TIMEOUT (1000 ticks = rise + 3 + 2000 clk)
    ppm_in = 1'b0;
    wait_until(last_rise + 1990);
    check("fs_early", 32'(failsafe), 0);
    wait_until(last_rise + 2010);
`ifdef PPM_FAILSAFE_EN
    check("fs_set", 32'(failsafe), 1);
    check("fs_fv", 32'(frame_valid), 0);
`else
    check("fs_off", 32'(failsafe), 0);
    check("fs_off_fv", 32'(frame_valid), 1);
`endif
    check("fs_cc", 32'(ch_count), 7);
    rd_check("fs_bank_ch0", 0, 210);
    rise_after(1200);
    send_n(150, 4);
    rise_after(400);
    step();
    check("fs_rec_fv", 32'(frame_valid), 1);
    check("fs_rec_fs", 32'(failsafe), 0);
    check("fs_rec_cc", 32'(ch_count), 4);

    // Asynchronous reset mid-frame after 3 channels
    send_n(220, 3);
    #3;
    reset  = 1'b1;
    ppm_in = 1'b0;
    #1;
    rd_ch = 4'd0;
    #1;
    check("arst_fv", 32'(frame_valid), 0);
    check("arst_sp", 32'(sync_pulse), 0);
    check("arst_cc", 32'(ch_count), 0);
    check("arst_ov", 32'(overrun), 0);
    check("arst_fs", 32'(failsafe), 0);
    check("arst_rd", 32'(rd_data), 0);
    step();
    reset        = 1'b0;
    last_rise    = cyc;
    base_commits = commits;
    // Channels before any sync are ignored; a sync alone does not commit
    send_n(220, 5);
    rise_after(400);
    repeat (3) step();
    check("post_rst_commits", 32'(commits), 32'(base_commits));
    check("post_rst_fv", 32'(frame_valid), 0);
    send_n(230, 4);
    rise_after(400);
    step();
    check("post_rst_fv2", 32'(frame_valid), 1);
    check("post_rst_cc", 32'(ch_count), 4);
    check("post_rst_ov", 32'(overrun), 0);
    rd_check("post_rst_ch3", 3, 230);
    step();
    check("post_rst_commits2", 32'(commits), 32'(base_commits + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ppm_frame_sequencer.md
# ppm_frame_sequencer

Synchronous controller for PPM receiver capture. It oversamples the raw PPM line, timestamps rising edges in prescaled ticks, and walks each frame through a channel-index state machine. Channel widths go into a shadow bank, which is committed atomically to an output bank when the frame is valid. Consumers such as the flight-control bridge read the output bank through a valid/ack handshake, and a failsafe flag reports signal loss.

## Interface
- CLK_DIV, 15: clk cycles per measurement tick (≥1)
- MAX_CH, 8: maximum channels per frame (1..15)
- MIN_CH, 4: minimum channels for a frame to be committed
- MIN_PULSE, 500: shortest legal channel interval, ticks
- SYNC_MIN, 3000: interval ≥ this value is a sync gap, ticks
- TIMEOUT, 20000: ticks without a rising edge before failsafe
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- ppm_in  in  1  raw PPM line, asynchronous to clk
- rd_ch  in  4  output-bank read index
- rd_data  out  16  committed width of channel rd_ch, ticks; combinational; 0 if rd_ch ≥ MAX_CH or ≥ ch_count
- ch_count  out  4  channel count of the last committed frame
- frame_valid  out  1  new committed frame available
- frame_ack  in  1  consumer acknowledge
- sync_pulse  out  1  one-clk strobe on each commit
- overrun  out  1  sticky flag: commit while the previous frame was unacknowledged
- failsafe  out  1  signal-loss indication

## Operation
- Input path: 2-flop synchroniser, then an edge register; rise = sync2 & ~sync_d.
- Prescaler counts 0..CLK_DIV-1 and emits a one-clk tick at wrap. It restarts at 0 on every rise.
- Width counter (16 bit):
  - Increments per tick and saturates at 0xFFFF.
  - On a rise, it captures its value as W, then resets to 0 in the same cycle.
- Channel index ch_idx: 4 bits, 0..MAX_CH.
- State machine:
  - HUNT (reset state): on a rise with W ≥ SYNC_MIN → CAPTURE, ch_idx=0. All other rises are ignored.
  - CAPTURE, on a rise with W ≥ SYNC_MIN:
    - If ch_idx ≥ MIN_CH → COMMIT.
    - Otherwise stay in CAPTURE with ch_idx=0; the partial frame is discarded silently.
  - CAPTURE, on a rise with W < SYNC_MIN:
    - If W < MIN_PULSE or ch_idx == MAX_CH → HUNT; the frame is discarded.
    - Otherwise shadow[ch_idx] ← W and ch_idx increments.
  - COMMIT (exactly 1 clk):
    - Output bank ← shadow; ch_count ← ch_idx; sync_pulse=1; frame_valid set.
    - If frame_valid was already 1 and frame_ack=0 this cycle, overrun=1.
    - ch_idx=0, then → CAPTURE.
    - A rise arriving during COMMIT is impossible because of the prescaler minimum; it needs no handling.
- Handshake:
  - frame_valid clears on the clk after frame_ack=1 is sampled.
  - If ack and COMMIT occur in the same cycle, COMMIT wins and frame_valid stays 1; this is not an overrun.
  - frame_ack while frame_valid=0 is ignored.
- overrun clears only on reset.
- Reset values: every output = 0, both banks = 0, state = HUNT, ch_idx = 0.
- Reset mid-frame discards the shadow bank.

## Timing
- A ppm_in rise is recognised 3 clk after it reaches the first synchroniser flop.
- COMMIT occupies the clk after the terminating sync rise.
- frame_valid, sync_pulse, ch_count and the output bank all update on the same edge, at the end of COMMIT.
- This gives 4 clk from the sync rise on ppm_in to frame_valid=1.
- rd_data follows rd_ch combinationally; it changes only at COMMIT.
- Width resolution is CLK_DIV clk. W counts whole ticks since the previous rise, so the quantisation error is under 1 tick.

## Configuration
- PPM_FAILSAFE_EN defined:
  - When the width counter reaches TIMEOUT with no rise, on that tick: failsafe=1, frame_valid=0, state → HUNT, ch_idx=0.
  - The output bank is retained.
  - failsafe clears at the next COMMIT.
- PPM_FAILSAFE_EN undefined:
  - failsafe is tied to 0 and TIMEOUT is unused.
  - The counter saturates and the state machine waits indefinitely.

## Test plan
- Nominal frame, defaults: gap 5000 ticks, then 8 intervals of 1500 ticks, then gap 5000 → frame_valid=1 and sync_pulse for one clk, 4 clk after the closing rise; ch_count=8; rd_data=1500 for ch 0..7; rd_ch=9 → 0.
- Runt pulse: interval 100 ticks mid-frame → state HUNT, no commit, output bank unchanged. The next valid frame after a sync commits normally.
- Channel overflow: 9 intervals of 1200 with MAX_CH=8 → discard, frame_valid stays 0. Short frame: 3 channels then sync → no commit; 4 channels then sync → commit, ch_count=4.
- Handshake:
  - Two frames with no ack → overrun=1, rd_data shows frame 2.
  - frame_ack asserted in the COMMIT cycle → frame_valid stays 1, overrun stays 0.
  - Ack on the next cycle → frame_valid=0 one clk later.
- Failsafe (macro defined): ppm_in held low 25000 ticks with TIMEOUT=20000 → failsafe=1 at tick 20000, frame_valid=0, old bank still readable; the next good frame sets frame_valid=1 and failsafe=0. With the macro undefined, failsafe stays 0.
- Reset asserted mid-frame after 3 channels → all outputs 0 asynchronously. After release, no commit until a sync gap plus ≥MIN_CH channels.
